// File: rtl/multi_blink.sv
// Multi-channel LED driver: one shared prescaler/blink/PWM time base feeding
// NUM_LEDS independent channels (off/on/blink/PWM) with retriggerable one-shots.
module multi_blink #(
    parameter int FREQ     = 50000000,
    parameter int SECS     = 1,
    parameter int NUM_LEDS = 4,
    parameter int PWM_BITS = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [2*NUM_LEDS-1:0]        mode_i,
    input  logic [PWM_BITS*NUM_LEDS-1:0] duty_i,
    input  logic [NUM_LEDS-1:0]          trig_i,
    output logic [NUM_LEDS-1:0]          led_o,
    output logic                         tick_o
);

    localparam int LIMIT  = FREQ * SECS;
    localparam int PS_W   = ($clog2(LIMIT) > 1) ? $clog2(LIMIT) : 1;
    // One extra bit so the shot counter can hold LIMIT itself.
    localparam int SHOT_W = PS_W + 1;

    localparam logic [PS_W-1:0]     PS_LAST   = PS_W'(LIMIT - 1);
    localparam logic [PS_W-1:0]     PS_ONE    = PS_W'(1);
    localparam logic [SHOT_W-1:0]   SHOT_LOAD = SHOT_W'(LIMIT);
    localparam logic [SHOT_W-1:0]   SHOT_ONE  = SHOT_W'(1);
    localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    if (LIMIT == 0) begin : g_bad_limit
        $error("multi_blink: FREQ*SECS must be nonzero");
    end
    if (NUM_LEDS < 1) begin : g_bad_num_leds
        $error("multi_blink: NUM_LEDS must be at least 1");
    end
    if (PWM_BITS < 1) begin : g_bad_pwm_bits
        $error("multi_blink: PWM_BITS must be at least 1");
    end

    logic [PS_W-1:0]     r_ps_cnt;
    logic                r_tick;
    logic                r_blink;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [SHOT_W-1:0]   r_shot [NUM_LEDS];
    logic [NUM_LEDS-1:0] r_led;

    logic [SHOT_W-1:0]   w_shot_next [NUM_LEDS];
    logic [NUM_LEDS-1:0] w_mode_val;
    logic [NUM_LEDS-1:0] w_led_next;

    // Shared time base: prescaler with tick/blink toggle, free-running PWM count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ps_cnt  <= '0;
            r_tick    <= 1'b0;
            r_blink   <= 1'b0;
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
            if (r_ps_cnt == PS_LAST) begin
                r_ps_cnt <= '0;
                r_tick   <= 1'b1;
                r_blink  <= ~r_blink;
            end else begin
                r_ps_cnt <= r_ps_cnt + PS_ONE;
                r_tick   <= 1'b0;
            end
        end
    end

    always_comb begin
        w_shot_next = r_shot;
        w_mode_val  = '0;
        w_led_next  = '0;
        for (int n = 0; n < NUM_LEDS; n++) begin
            // A retrigger reloads rather than extends the remaining count.
            if (trig_i[n]) begin
                w_shot_next[n] = SHOT_LOAD;
            end else if (r_shot[n] != '0) begin
                w_shot_next[n] = r_shot[n] - SHOT_ONE;
            end
            case (mode_e'(mode_i[2*n +: 2]))
                MODE_OFF:   w_mode_val[n] = 1'b0;
                MODE_ON:    w_mode_val[n] = 1'b1;
                MODE_BLINK: w_mode_val[n] = r_blink;
                MODE_PWM:   w_mode_val[n] = (r_pwm_cnt < duty_i[PWM_BITS*n +: PWM_BITS]);
                default:    w_mode_val[n] = 1'b0;
            endcase
            w_led_next[n] = w_mode_val[n] | (w_shot_next[n] != '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int n = 0; n < NUM_LEDS; n++) begin
                r_shot[n] <= '0;
            end
            r_led <= '0;
        end else begin
            for (int n = 0; n < NUM_LEDS; n++) begin
                r_shot[n] <= w_shot_next[n];
            end
            r_led <= w_led_next;
        end
    end

    assign led_o  = r_led;
    assign tick_o = r_tick;

endmodule

// File: tb/tb_multi_blink.sv
// Directed bench for multi_blink with LIMIT=4, four channels and 2-bit PWM;
// expected values are derived from the edge index since reset release.
module tb_multi_blink;

    logic       clk;
    logic       rst;
    logic [7:0] mode;
    logic [7:0] duty;
    logic [3:0] trig;
    logic [3:0] led;
    logic       tick;

    int n_checks;
    int n_pass;
    int e;

    multi_blink #(
        .FREQ    (4),
        .SECS    (1),
        .NUM_LEDS(4),
        .PWM_BITS(2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .mode_i(mode),
        .duty_i(duty),
        .trig_i(trig),
        .led_o (led),
        .tick_o(tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        e = 0;
    endtask

    initial begin
        int hi;
        int win;
        logic [1:0] dv;
        logic [3:0] exp_led;
        int duties [3];

        n_checks = 0;
        n_pass   = 0;
        e        = 0;
        rst      = 1'b1;
        mode     = '0;
        duty     = '0;
        trig     = '0;
        duties   = '{0, 1, 3};

        // Reset behaviour and tick cadence.
        repeat (3) step();
        check("reset_led", {28'd0, led}, 32'd0);
        check("reset_tick", {31'd0, tick}, 32'd0);
        rst = 1'b0;
        e = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("tick_e%0d", e), {31'd0, tick}, {31'd0, (e % 4 == 0)});
        end

        // Static and blink modes: ch0 OFF, ch1 ON, ch2 BLINK, ch3 OFF.
        mode = 8'b00_10_01_00;
        do_reset();
        check("reset_with_modes", {28'd0, led}, 32'd0);
        for (int k = 1; k <= 16; k++) begin
            step();
            exp_led = {1'b0, 1'((((e - 1) / 4) % 2)), 1'b1, 1'b0};
            check($sformatf("blink_e%0d", e), {28'd0, led}, {28'd0, exp_led});
        end

        // PWM on ch3; PWM count before edge e is (e-1)%4.
        mode = 8'b11_00_00_00;
        foreach (duties[i]) begin
            dv = 2'(duties[i]);
            duty = {dv, 6'd0};
            hi = 0;
            for (int w = 0; w < 4; w++) begin
                win = 0;
                for (int k = 0; k < 4; k++) begin
                    step();
                    check($sformatf("pwm_d%0d_e%0d", dv, e), {31'd0, led[3]},
                          {31'd0, (((e - 1) % 4) < int'(dv))});
                    win += int'(led[3]);
                end
                check($sformatf("pwm_win_d%0d_w%0d", dv, w), win, int'(dv));
                hi += win;
            end
            check($sformatf("pwm_total_d%0d", dv), hi, 4 * int'(dv));
        end

        // Single one-shot on ch0 with every channel OFF.
        mode = '0;
        duty = '0;
        step();
        check("shot_pre", {31'd0, led[0]}, 32'd0);
        trig = 4'b0001;
        step();
        trig = 4'b0000;
        check("shot_0", {31'd0, led[0]}, 32'd1);
        for (int k = 1; k < 8; k++) begin
            step();
            check($sformatf("shot_%0d", k), {31'd0, led[0]}, {31'd0, (k < 4)});
        end

        // Retrigger two edges after the first: six consecutive high cycles.
        hi = 0;
        trig = 4'b0001;
        step();
        trig = 4'b0000;
        hi += int'(led[0]);
        step();
        hi += int'(led[0]);
        trig = 4'b0001;
        step();
        trig = 4'b0000;
        hi += int'(led[0]);
        for (int k = 3; k < 8; k++) begin
            step();
            check($sformatf("retrig_%0d", k), {31'd0, led[0]}, {31'd0, (k < 6)});
            hi += int'(led[0]);
        end
        check("retrig_total", hi, 6);
        check("retrig_others", {29'd0, led[3:1]}, 32'd0);

        // Asynchronous reset one cycle into a shot, between edges.
        trig = 4'b0001;
        step();
        trig = 4'b0000;
        check("mid_shot_active", {31'd0, led[0]}, 32'd1);
        step();
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_led", {28'd0, led}, 32'd0);
        check("async_rst_tick", {31'd0, tick}, 32'd0);
        step();
        step();
        rst = 1'b0;
        e = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("post_rst_led_e%0d", e), {28'd0, led}, 32'd0);
            check($sformatf("post_rst_tick_e%0d", e), {31'd0, tick}, {31'd0, (e % 4 == 0)});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
